// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_pkg : shared state encoding and register map for the calculator |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package calc_pkg;

  typedef enum logic [2:0] {
    ST_A_HI  = 3'd0,
    ST_A_LO  = 3'd1,
    ST_B_HI  = 3'd2,
    ST_B_LO  = 3'd3,
    ST_READY = 3'd4,
    ST_EXEC  = 3'd5,
    ST_WB    = 3'd6
  } calc_state_e;

  localparam int unsigned CALC_OP_W = 3;

  // Register bank map shared with the ALU datapath
  localparam int unsigned REG_OPA = 0;
  localparam int unsigned REG_OPB = 1;
  localparam int unsigned REG_RES = 2;

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_edge : 2-flop synchronizer plus registered rising-edge pulse     |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_pulse;

  // Pulse lands three cycles after the pin rises; a held pin yields one pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= r_sync2 & ~r_sync3;
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_sequencer : operand entry and execute sequencer for the keypad  |
// | Rev 1.0        : initial release                                     |
// +----------------------------------------------------------------------+
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4,
  parameter int ADDR_W = 2,
  parameter int OP_W   = CALC_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [NIB_W-1:0]  key_code,
  input  logic              exec_btn,
  input  logic              clear,
  input  logic [OP_W-1:0]   op_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] reg_di,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic              reg_we,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_go,
  output logic              done,
  output logic [2:0]        phase
);

  calc_state_e       r_state;
  calc_state_e       w_state_nxt;
  logic [NIB_W-1:0]  r_hold;
  logic [NIB_W-1:0]  w_hold_nxt;
  logic [DATA_W-1:0] r_di;
  logic [DATA_W-1:0] w_di_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [OP_W-1:0]   r_op;
  logic [OP_W-1:0]   w_op_nxt;
  logic              r_go;
  logic              w_go_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [2:0]        r_phase;
  logic [ADDR_W-1:0] r_rd_a;
  logic [ADDR_W-1:0] r_rd_b;
  logic              w_exec;

  btn_edge u_exec_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (exec_btn),
    .o_pulse (w_exec)
  );

  // State register together with the registered outputs it drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_A_HI;
      r_hold    <= '0;
      r_di      <= '0;
      r_wr_addr <= '0;
      r_we      <= 1'b0;
      r_op      <= '0;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      r_phase   <= 3'd0;
      r_rd_a    <= ADDR_W'(REG_OPA);
      r_rd_b    <= ADDR_W'(REG_OPB);
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_di      <= w_di_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_we      <= w_we_nxt;
      r_op      <= w_op_nxt;
      r_go      <= w_go_nxt;
      r_done    <= w_done_nxt;
      r_phase   <= r_state;
      r_rd_a    <= ADDR_W'(REG_OPA);
      r_rd_b    <= ADDR_W'(REG_OPB);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_A_HI;
    end else begin
      case (r_state)
        ST_A_HI:  if (key_valid) w_state_nxt = ST_A_LO;
        ST_A_LO:  if (key_valid) w_state_nxt = ST_B_HI;
        ST_B_HI:  if (key_valid) w_state_nxt = ST_B_LO;
        ST_B_LO:  if (key_valid) w_state_nxt = ST_READY;
        ST_READY: begin
          if (w_exec)         w_state_nxt = ST_EXEC;
          else if (key_valid) w_state_nxt = ST_A_LO;
        end
        ST_EXEC:  w_state_nxt = ST_WB;
        ST_WB:    w_state_nxt = ST_READY;
        default:  w_state_nxt = ST_A_HI;
      endcase
    end
  end

  // Next values for the output registers; pulses default low each cycle
  always_comb begin
    w_hold_nxt    = r_hold;
    w_di_nxt      = r_di;
    w_wr_addr_nxt = r_wr_addr;
    w_we_nxt      = 1'b0;
    w_op_nxt      = r_op;
    w_go_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    if (clear) begin
      w_hold_nxt = '0;
    end else begin
      case (r_state)
        ST_A_HI, ST_B_HI: begin
          if (key_valid) w_hold_nxt = key_code;
        end
        ST_A_LO: begin
          if (key_valid) begin
            w_di_nxt      = {r_hold, key_code};
            w_wr_addr_nxt = ADDR_W'(REG_OPA);
            w_we_nxt      = 1'b1;
          end
        end
        ST_B_LO: begin
          if (key_valid) begin
            w_di_nxt      = {r_hold, key_code};
            w_wr_addr_nxt = ADDR_W'(REG_OPB);
            w_we_nxt      = 1'b1;
          end
        end
        ST_READY: begin
          if (w_exec) begin
            w_op_nxt = op_in;
            w_go_nxt = 1'b1;
          end else if (key_valid) begin
            w_hold_nxt = key_code;
          end
        end
        ST_EXEC: begin
          w_di_nxt      = alu_result;
          w_wr_addr_nxt = ADDR_W'(REG_RES);
          w_we_nxt      = 1'b1;
        end
        ST_WB: begin
          w_done_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign reg_di      = r_di;
  assign reg_wr_addr = r_wr_addr;
  assign reg_we      = r_we;
  assign rd_addr_a   = r_rd_a;
  assign rd_addr_b   = r_rd_b;
  assign alu_op      = r_op;
  assign alu_go      = r_go;
  assign done        = r_done;
  assign phase       = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_calc_sequencer : table vectors plus write scoreboard              |
// | Rev 1.0           : initial release                                  |
// +----------------------------------------------------------------------+
module tb_calc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       exec_btn;
  logic       clear;
  logic [2:0] op_in;
  logic [7:0] alu_result;
  logic [7:0] reg_di;
  logic [1:0] reg_wr_addr;
  logic       reg_we;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [2:0] alu_op;
  logic       alu_go;
  logic       done;
  logic [2:0] phase;

  calc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .exec_btn    (exec_btn),
    .clear       (clear),
    .op_in       (op_in),
    .alu_result  (alu_result),
    .reg_di      (reg_di),
    .reg_wr_addr (reg_wr_addr),
    .reg_we      (reg_we),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .alu_op      (alu_op),
    .alu_go      (alu_go),
    .done        (done),
    .phase       (phase)
  );

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic [3:0] k0, k1, k2, k3;
    logic [2:0] op;
    logic [7:0] res;
  } vec_t;

  wr_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         go_cnt = 0;
  int         done_cnt = 0;
  logic [2:0] exp_op = 3'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pops the oldest expected write
  initial begin
    logic prev_we;
    wr_t  e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_we) begin
          check("we_one_cycle", {31'd0, prev_we}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_write", {22'd0, reg_wr_addr, reg_di}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {30'd0, reg_wr_addr}, {30'd0, e.addr});
            check("wr_data", {24'd0, reg_di}, {24'd0, e.data});
          end
        end
        if (alu_go) begin
          go_cnt++;
          check("alu_op", {29'd0, alu_op}, {29'd0, exp_op});
        end
        if (done) done_cnt++;
        prev_we = reg_we;
      end else begin
        prev_we = 1'b0;
      end
    end
  end

  task automatic send_key(input logic [3:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_exec(input string name, input int g0, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    exec_btn = 1'b0;
    idle(5);
    check({name, "_go_count"}, go_cnt - g0, 1);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_phase"}, {29'd0, phase}, 32'd4);
  endtask

  task automatic run_exec(input string name, input logic [2:0] op, input logic [7:0] res, input int hold);
    int g0, d0;
    g0 = go_cnt;
    d0 = done_cnt;
    op_in      = op;
    alu_result = res;
    exp_op     = op;
    exp_q.push_back('{addr: 2'd2, data: res});
    exec_btn = 1'b1;
    idle(hold);
    wait_exec(name, g0, d0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_reg_di"}, {24'd0, reg_di}, 32'd0);
    check({name, "_reg_wr_addr"}, {30'd0, reg_wr_addr}, 32'd0);
    check({name, "_reg_we"}, {31'd0, reg_we}, 32'd0);
    check({name, "_rd_addr_a"}, {30'd0, rd_addr_a}, 32'd0);
    check({name, "_rd_addr_b"}, {30'd0, rd_addr_b}, 32'd1);
    check({name, "_alu_op"}, {29'd0, alu_op}, 32'd0);
    check({name, "_alu_go"}, {31'd0, alu_go}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_phase"}, {29'd0, phase}, 32'd0);
  endtask

  initial begin
    vec_t vecs[3];
    int   g0, d0;
    vecs[0] = '{k0: 4'h3, k1: 4'hA, k2: 4'h0, k3: 4'h5, op: 3'd2, res: 8'h3F};
    vecs[1] = '{k0: 4'hF, k1: 4'hF, k2: 4'h0, k3: 4'h0, op: 3'd7, res: 8'hC3};
    vecs[2] = '{k0: 4'h0, k1: 4'h0, k2: 4'hF, k3: 4'hF, op: 3'd0, res: 8'h00};

    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; exec_btn = 1'b0;
    clear = 1'b0; op_in = 3'd0; alu_result = 8'h00;
    #22;
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    check_reset_outputs("rst_rel");

    // Table-driven operand entry and execute
    foreach (vecs[i]) begin
      exp_q.push_back('{addr: 2'd0, data: {vecs[i].k0, vecs[i].k1}});
      exp_q.push_back('{addr: 2'd1, data: {vecs[i].k2, vecs[i].k3}});
      send_key(vecs[i].k0);
      send_key(vecs[i].k1);
      send_key(vecs[i].k2);
      send_key(vecs[i].k3);
      idle(2);
      check("entry_phase", {29'd0, phase}, 32'd4);
      run_exec("vec_exec", vecs[i].op, vecs[i].res, (i == 0) ? 20 : 6);
    end

    // Key and execute strobe in the same READY cycle: execute wins
    g0 = go_cnt; d0 = done_cnt;
    op_in = 3'd5; alu_result = 8'h81; exp_op = 3'd5;
    exp_q.push_back('{addr: 2'd2, data: 8'h81});
    exec_btn = 1'b1;
    idle(3);
    key_valid = 1'b1; key_code = 4'h9;
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_exec("simul", g0, d0);
    send_key(4'h7);
    idle(2);
    check("key_in_ready_phase", {29'd0, phase}, 32'd1);
    exp_q.push_back('{addr: 2'd0, data: 8'h71});
    exp_q.push_back('{addr: 2'd1, data: 8'h23});
    send_key(4'h1);
    send_key(4'h2);
    send_key(4'h3);
    idle(2);

    // Execute in A_LO is dropped
    send_key(4'hC);
    g0 = go_cnt;
    exec_btn = 1'b1;
    idle(6);
    exec_btn = 1'b0;
    idle(6);
    check("exec_in_alo_go", go_cnt - g0, 0);
    check("exec_in_alo_phase", {29'd0, phase}, 32'd1);
    exp_q.push_back('{addr: 2'd0, data: 8'hCD});
    exp_q.push_back('{addr: 2'd1, data: 8'h11});
    send_key(4'hD);
    send_key(4'h1);
    send_key(4'h1);
    idle(2);

    // Keys held through EXEC and WB are ignored
    g0 = go_cnt; d0 = done_cnt;
    op_in = 3'd1; alu_result = 8'h55; exp_op = 3'd1;
    exp_q.push_back('{addr: 2'd2, data: 8'h55});
    exec_btn = 1'b1;
    idle(4);
    key_valid = 1'b1; key_code = 4'hE;
    idle(2);
    key_valid = 1'b0;
    wait_exec("keys_in_exec", g0, d0);
    exp_q.push_back('{addr: 2'd0, data: 8'h45});
    exp_q.push_back('{addr: 2'd1, data: 8'h66});
    send_key(4'h4);
    send_key(4'h5);
    send_key(4'h6);
    send_key(4'h6);
    idle(2);

    // Clear in B_LO coinciding with a key
    exp_q.push_back('{addr: 2'd0, data: 8'h12});
    send_key(4'h1);
    send_key(4'h2);
    send_key(4'h3);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 4'h4; clear = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; clear = 1'b0;
    idle(2);
    check("clear_phase", {29'd0, phase}, 32'd0);
    exp_q.push_back('{addr: 2'd0, data: 8'h56});
    exp_q.push_back('{addr: 2'd1, data: 8'h78});
    send_key(4'h5);
    send_key(4'h6);
    send_key(4'h7);
    send_key(4'h8);
    idle(2);
    check("after_clear_phase", {29'd0, phase}, 32'd4);

    // Asynchronous reset while alu_go is high
    op_in = 3'd3; exp_op = 3'd3;
    exec_btn = 1'b1;
    idle(4);
    check("pre_rst_alu_go", {31'd0, alu_go}, 32'd1);
    #2;
    rst_n = 1'b0;
    key_valid = 1'b1; key_code = 4'hB;
    #1;
    check_reset_outputs("async_rst");
    exec_btn = 1'b0;
    idle(3);
    key_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);
    check("post_rst_phase", {29'd0, phase}, 32'd0);
    exp_q.push_back('{addr: 2'd0, data: 8'hAB});
    send_key(4'hA);
    send_key(4'hB);
    idle(3);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
